// File: rtl/tdo_shift_scheduler.sv
// rtl/tdo_shift_scheduler.sv - round-robin arbitrated, MSB-first TDO serializer
// Grants one requester, latches its word and shifts it out on each shift_en cycle.
module tdo_shift_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*WIDTH-1:0]   data_in,
   input  logic                       shift_en,
   input  logic                       abort,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       busy,
   output logic                       tdo,
   output logic                       done,
   output logic [$clog2(WIDTH+1)-1:0] bits_left
);
   localparam int BW = $clog2(WIDTH+1);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             r_state;
   logic [NUM_REQ-1:0] r_gnt;
   logic               r_busy;
   logic               r_tdo;
   logic               r_done;
   logic [BW-1:0]      r_bits;
   logic [WIDTH-1:0]   r_shreg;
   logic [IW-1:0]      r_last;

   logic [IW-1:0]      w_sel;
   logic [IW-1:0]      w_idx;
   logic               w_any;

   // Search starts one past the last grant so the previous winner is considered last.
   always_comb begin
      w_sel = r_last;
      w_idx = '0;
      w_any = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = IW'((int'(r_last) + k) % NUM_REQ);
         if (!w_any && req[w_idx]) begin
            w_any = 1'b1;
            w_sel = w_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_busy  <= 1'b0;
         r_tdo   <= 1'b0;
         r_done  <= 1'b0;
         r_bits  <= '0;
         r_shreg <= '0;
         r_last  <= IW'(NUM_REQ - 1);
      end else begin
         r_gnt  <= '0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_shreg <= data_in[w_sel*WIDTH +: WIDTH];
                  r_gnt   <= NUM_REQ'(1) << w_sel;
                  r_last  <= w_sel;
                  r_busy  <= 1'b1;
                  r_bits  <= BW'(WIDTH);
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // abort wins over shift_en; tdo keeps the last bit already driven
               if (abort) begin
                  r_busy  <= 1'b0;
                  r_bits  <= '0;
                  r_state <= S_IDLE;
               end else if (shift_en) begin
                  r_tdo   <= r_shreg[WIDTH-1];
                  r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                  r_bits  <= r_bits - BW'(1);
                  if (r_bits == BW'(1)) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_bits  <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign busy      = r_busy;
   assign tdo       = r_tdo;
   assign done      = r_done;
   assign bits_left = r_bits;
endmodule

// File: tb/tb_tdo_shift_scheduler.sv
// tb/tb_tdo_shift_scheduler.sv - self-checking bench for tdo_shift_scheduler
// Reference model tracks last grant, expected tdo and remaining bit count arithmetically.
module tb_tdo_shift_scheduler;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req;
   logic [63:0] data_in;
   logic        shift_en;
   logic        abort;
   logic [1:0]  gnt;
   logic        busy, tdo, done;
   logic [5:0]  bits_left;

   logic [2:0]  req3;
   logic [23:0] data3;
   logic        sh3, ab3;
   logic [2:0]  gnt3;
   logic        busy3, tdo3, done3;
   logic [3:0]  bl3;

   int   checks = 0;
   int   errors = 0;
   int   m_last, m_last3;
   logic m_tdo, m_tdo3;

   always #5 clk = ~clk;

   tdo_shift_scheduler #(.NUM_REQ(2), .WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .shift_en(shift_en),
      .abort(abort), .gnt(gnt), .busy(busy), .tdo(tdo), .done(done), .bits_left(bits_left)
   );

   tdo_shift_scheduler #(.NUM_REQ(3), .WIDTH(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .data_in(data3), .shift_en(sh3),
      .abort(ab3), .gnt(gnt3), .busy(busy3), .tdo(tdo3), .done(done3), .bits_left(bl3)
   );

   function automatic int rr(input logic [7:0] r, input int last, input int n);
      for (int k = 1; k <= n; k++)
         if (((r >> ((last + k) % n)) & 8'd1) != 8'd0) return (last + k) % n;
      return -1;
   endfunction

   task automatic wait_gnt(input int sel);
      int n;
      logic [1:0] eg;
      eg = 2'(1 << sel);
      n = 0;
      do begin @(negedge clk); n++; end while (gnt === 2'b00 && n < 20);
      checks++;
      if (n != 1) begin errors++; $display("FAIL gnt_latency got %0d cycles want 1", n); end
      checks++;
      if (gnt !== eg) begin errors++; $display("FAIL gnt got %b want %b", gnt, eg); end
      checks++;
      if (busy !== 1'b1 || bits_left !== 6'd32 || done !== 1'b0) begin
         errors++;
         $display("FAIL capture busy=%b bits_left=%0d done=%b want 1/32/0", busy, bits_left, done);
      end
      m_last = sel;
   endtask

   // mode 0: shift_en always high, 1: pattern 1,0,0, 2: random
   task automatic shift_bits(input logic [31:0] word, input int mode, input int stop);
      int b, cyc;
      logic en;
      b = 32;
      cyc = 0;
      while (b > stop && cyc < 4000) begin
         case (mode)
            0:       en = 1'b1;
            1:       en = (cyc % 3 == 0);
            default: en = 1'($urandom_range(0, 1));
         endcase
         shift_en = en;
         @(negedge clk);
         cyc++;
         if (en) begin m_tdo = word[5'(b - 1)]; b--; end
         checks++;
         if (tdo !== m_tdo || bits_left !== 6'(b)) begin
            errors++;
            $display("FAIL shift tdo=%b bits_left=%0d want %b/%0d", tdo, bits_left, m_tdo, b);
         end
         checks++;
         if (done !== (en && b == 0) || busy !== 1'b1 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL flags done=%b busy=%b gnt=%b want %b/1/00", done, busy, gnt, en && b == 0);
         end
      end
      shift_en = 1'b0;
      checks++;
      if (b != stop) begin errors++; $display("FAIL shift_timeout bits got %0d want %0d", b, stop); end
      if (stop == 0) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || bits_left !== 6'd0 || gnt !== 2'b00) begin
            errors++;
            $display("FAIL done_clear done=%b busy=%b bits_left=%0d gnt=%b want 0/0/0/00",
                     done, busy, bits_left, gnt);
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req = '0; data_in = '0; shift_en = 1'b0; abort = 1'b0;
      req3 = '0; data3 = '0; sh3 = 1'b0; ab3 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (gnt !== 2'b00 || busy !== 1'b0 || tdo !== 1'b0 || done !== 1'b0 || bits_left !== 6'd0) begin
         errors++;
         $display("FAIL reset gnt=%b busy=%b tdo=%b done=%b bits_left=%0d want all 0",
                  gnt, busy, tdo, done, bits_left);
      end
      checks++;
      if (gnt3 !== 3'b000 || busy3 !== 1'b0 || tdo3 !== 1'b0 || done3 !== 1'b0 || bl3 !== 4'd0) begin
         errors++;
         $display("FAIL reset3 gnt=%b busy=%b tdo=%b done=%b bits_left=%0d want all 0",
                  gnt3, busy3, tdo3, done3, bl3);
      end
      rst_n = 1'b1;
      m_last = 1; m_tdo = 1'b0; m_last3 = 2; m_tdo3 = 1'b0;
   endtask

   task automatic test_single;
      data_in = {32'h1234_5678, 32'hA5A5_0F0F};
      req = 2'b01;
      wait_gnt(rr({6'd0, req}, m_last, 2));
      req = 2'b00;
      shift_bits(32'hA5A5_0F0F, 0, 0);
   endtask

   task automatic test_back_to_back;
      int sel;
      data_in = {32'h0000_0000, 32'hFFFF_FFFF};
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         sel = rr(8'd3, m_last, 2);
         wait_gnt(sel);
         if (i == 3) req = 2'b00;
         shift_bits(sel == 1 ? 32'h0000_0000 : 32'hFFFF_FFFF, 0, 0);
      end
   endtask

   task automatic test_toggle;
      logic [31:0] w;
      w = $urandom;
      data_in = {w, ~w};
      req = 2'b10;
      wait_gnt(rr({6'd0, req}, m_last, 2));
      req = 2'b00;
      shift_bits(w, 1, 0);
   endtask

   task automatic test_abort;
      int sel, other;
      data_in = {$urandom, $urandom};
      req = 2'b11;
      sel = rr(8'd3, m_last, 2);
      wait_gnt(sel);
      shift_bits(32'(data_in >> (32 * sel)), 0, 10);
      abort = 1'b1;
      shift_en = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      shift_en = 1'b0;
      checks++;
      if (busy !== 1'b0 || bits_left !== 6'd0 || done !== 1'b0 || tdo !== m_tdo) begin
         errors++;
         $display("FAIL abort busy=%b bits_left=%0d done=%b tdo=%b want 0/0/0/%b",
                  busy, bits_left, done, tdo, m_tdo);
      end
      other = rr(8'd3, m_last, 2);
      wait_gnt(other);
      req = 2'b00;
      shift_bits(32'(data_in >> (32 * other)), 2, 0);
   endtask

   task automatic test_reset_mid;
      data_in = {$urandom, $urandom};
      req = 2'b01;
      wait_gnt(rr({6'd0, req}, m_last, 2));
      req = 2'b00;
      shift_bits(data_in[31:0], 0, 17);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (gnt !== 2'b00 || busy !== 1'b0 || tdo !== 1'b0 || done !== 1'b0 || bits_left !== 6'd0) begin
         errors++;
         $display("FAIL async_reset gnt=%b busy=%b tdo=%b done=%b bits_left=%0d want all 0",
                  gnt, busy, tdo, done, bits_left);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1; m_tdo = 1'b0; m_last3 = 2; m_tdo3 = 1'b0;
      req = 2'b11;
      wait_gnt(0);
      req = 2'b00;
      shift_bits(data_in[31:0], 2, 0);
   endtask

   task automatic test_random;
      int sel;
      for (int i = 0; i < 6; i++) begin
         data_in = {$urandom, $urandom};
         req = 2'($urandom_range(1, 3));
         sel = rr({6'd0, req}, m_last, 2);
         wait_gnt(sel);
         req = 2'b00;
         shift_bits(32'(data_in >> (32 * sel)), 2, 0);
      end
   endtask

   task automatic xfer3(input logic [2:0] r);
      int n, b, cyc, sel;
      logic en;
      logic [7:0] w;
      sel = rr({5'd0, r}, m_last3, 3);
      req3 = r;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt3 === 3'b000 && n < 20);
      req3 = 3'b000;
      checks++;
      if (n != 1 || gnt3 !== 3'(1 << sel) || bl3 !== 4'd8) begin
         errors++;
         $display("FAIL gnt3 got %b after %0d cycles bits_left=%0d want %b after 1, 8",
                  gnt3, n, bl3, 3'(1 << sel));
      end
      m_last3 = sel;
      w = 8'(data3 >> (8 * sel));
      b = 8;
      cyc = 0;
      while (b > 0 && cyc < 1000) begin
         en = 1'($urandom_range(0, 1));
         sh3 = en;
         @(negedge clk);
         cyc++;
         if (en) begin m_tdo3 = w[3'(b - 1)]; b--; end
         checks++;
         if (tdo3 !== m_tdo3 || bl3 !== 4'(b) || done3 !== (en && b == 0)) begin
            errors++;
            $display("FAIL shift3 tdo=%b bits_left=%0d done=%b want %b/%0d/%b",
                     tdo3, bl3, done3, m_tdo3, b, en && b == 0);
         end
      end
      sh3 = 1'b0;
      @(negedge clk);
      checks++;
      if (done3 !== 1'b0 || busy3 !== 1'b0 || b != 0) begin
         errors++;
         $display("FAIL done3 done=%b busy=%b bits=%0d want 0/0/0", done3, busy3, b);
      end
   endtask

   task automatic test_three;
      data3 = {8'h81, 8'h3C, 8'h5A};
      xfer3(3'b001);
      xfer3(3'b101);
      xfer3(3'b111);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_toggle();
      test_abort();
      test_reset_mid();
      test_random();
      test_three();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
